sdp_ram_be: RTL and testbench

//  Simple-dual-port RAM: one write port, one read port, shared clock. Generalises
//  the single-port RAM with byte-lane write enables, configurable read latency,

---
 rtl/sdp_ram_be.sv | 111 +++++++++++
 tb/tb_sdp_ram_be.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_be.sv
// rtl/sdp_ram_be.sv - simple-dual-port RAM with byte enables, zero-init engine, 1/2-cycle read latency
module sdp_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1,
  parameter int WR_FIRST   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      ready
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   init_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_ok, rd_ok, rd_in_range, wr_in_range;
  logic [DATA_WIDTH-1:0] old_word, merged_word, rd_word;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  assign ready       = (state == RUN);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_ok       = wr_en & ready & wr_in_range;
  assign rd_ok       = rd_en & ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && init_ptr == LAST_W) state_next = RUN;
  end

  // Init and user writes share the single write port; INIT owns it until ready.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        mem[init_ptr[ADDR_WIDTH-1:0]] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < NB; i++)
          if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    old_word = rd_in_range ? mem[rd_addr] : '0;
    merged_word = old_word;
    for (int i = 0; i < NB; i++)
      if (wr_be[i]) merged_word[8*i +: 8] = wr_data[8*i +: 8];
    rd_word = old_word;
    if (WR_FIRST != 0 && wr_ok && wr_addr == rd_addr) rd_word = merged_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_ok;
      if (rd_ok) s1_data <= rd_word;
    end
  end

  // Optional second stage: data only advances with a valid so rd_data holds between reads.
  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end
      assign rd_data  = s2_data;
      assign rd_valid = s2_valid;
    end else begin : g_lat1
      assign rd_data  = s1_data;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_ram_be.sv
// tb/tb_sdp_ram_be.sv - directed bench for sdp_ram_be across WR_FIRST, RD_LATENCY and DEPTH variants
module tb_sdp_ram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  logic [31:0] rd_data_a, rd_data_w, rd_data_l, rd_data_s;
  logic        rd_valid_a, rd_valid_w, rd_valid_l, rd_valid_s;
  logic        ready_a, ready_w, ready_l, ready_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdp_ram_be dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .ready(ready_a));

  sdp_ram_be #(.WR_FIRST(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w),
    .rd_valid(rd_valid_w), .ready(ready_w));

  sdp_ram_be #(.RD_LATENCY(2)) dut_l (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_l),
    .rd_valid(rd_valid_l), .ready(ready_l));

  sdp_ram_be #(.DEPTH(200)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s),
    .rd_valid(rd_valid_s), .ready(ready_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    repeat (3) tick();
    checks++;
    if ({ready_a, ready_w, ready_l, ready_s} !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", {ready_a, ready_w, ready_l, ready_s});
    end
    checks++;
    if ({rd_valid_a, rd_valid_w, rd_valid_l, rd_valid_s} !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b expected 0000", {rd_valid_a, rd_valid_w, rd_valid_l, rd_valid_s});
    end
    checks++;
    if (rd_data_a !== 32'h0 || rd_data_l !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0", rd_data_a, rd_data_l);
    end
  endtask

  task automatic test_init();
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 8'h30; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 8'h30;
    for (int k = 1; k <= 255; k++) begin
      if (k == 150) begin wr_en = 1'b0; rd_en = 1'b0; end
      tick();
      checks++;
      if ({rd_valid_a, rd_valid_w, rd_valid_l, rd_valid_s} !== 4'b0000) begin
        errors++; $display("FAIL init_no_valid k=%0d: got %b expected 0000", k,
                           {rd_valid_a, rd_valid_w, rd_valid_l, rd_valid_s});
      end
      checks++;
      if (ready_a !== 1'b0) begin
        errors++; $display("FAIL init_ready256 k=%0d: got %b expected 0", k, ready_a);
      end
      checks++;
      if (ready_s !== (k >= 200)) begin
        errors++; $display("FAIL init_ready200 k=%0d: got %b expected %b", k, ready_s, (k >= 200));
      end
    end
    tick();
    checks++;
    if ({ready_a, ready_w, ready_l} !== 3'b111) begin
      errors++; $display("FAIL init_ready_rise: got %b expected 111", {ready_a, ready_w, ready_l});
    end
    for (int a = 0; a < 256; a++) begin
      rd_en = 1'b1; rd_addr = 8'(a);
      tick();
      checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h0) begin
        errors++; $display("FAIL init_zero addr=%0d: got v=%b d=%h expected v=1 d=0", a, rd_valid_a, rd_data_a);
      end
      checks++;
      if (rd_valid_s !== 1'b1 || rd_data_s !== 32'h0 || rd_data_w !== 32'h0) begin
        errors++; $display("FAIL init_zero_var addr=%0d: got v=%b d=%h/%h expected v=1 d=0", a,
                           rd_valid_s, rd_data_s, rd_data_w);
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid_a !== 1'b0) begin
      errors++; $display("FAIL init_valid_drop: got %b expected 0", rd_valid_a);
    end
    tick();
    checks++;
    if (rd_valid_l !== 1'b0) begin
      errors++; $display("FAIL init_valid_drop_l2: got %b expected 0", rd_valid_l);
    end
  endtask

  task automatic test_byte_enable();
    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 32'hAABB_CCDD; wr_be = 4'hF;
    tick();
    wr_data = 32'h1122_3344; wr_be = 4'b0101;
    tick();
    wr_data = 32'hFFFF_FFFF; wr_be = 4'b0000;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 32'hAA22_CC44) begin
      errors++; $display("FAIL byte_enable: got v=%b d=%h expected v=1 d=aa22cc44", rd_valid_a, rd_data_a);
    end
    tick();
    checks++;
    if (rd_valid_l !== 1'b1 || rd_data_l !== 32'hAA22_CC44 || rd_valid_a !== 1'b0) begin
      errors++; $display("FAIL byte_enable_l2: got v=%b d=%h va=%b expected v=1 d=aa22cc44 va=0",
                         rd_valid_l, rd_data_l, rd_valid_a);
    end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 8'h20;
    tick();
    checks++;
    if (rd_data_a !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL collision_wr_first: got %h expected deadbeef", rd_data_a);
    end
    checks++;
    if (rd_data_w !== 32'h0) begin
      errors++; $display("FAIL collision_rd_first: got %h expected 00000000", rd_data_w);
    end
    wr_addr = 8'h21; wr_data = 32'h1234_5678; wr_be = 4'b0011; rd_addr = 8'h21;
    tick();
    checks++;
    if (rd_data_a !== 32'h0000_5678 || rd_data_w !== 32'h0) begin
      errors++; $display("FAIL collision_partial: got %h/%h expected 00005678/00000000", rd_data_a, rd_data_w);
    end
    wr_addr = 8'h22; wr_data = 32'h5555_5555; wr_be = 4'hF; rd_addr = 8'h21;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (rd_data_w !== 32'h0000_5678 || rd_data_a !== 32'h0000_5678) begin
      errors++; $display("FAIL collision_indep: got %h/%h expected 00005678", rd_data_w, rd_data_a);
    end
    tick();
  endtask

  task automatic test_latency();
    logic [31:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = 32'hA000_0000 + 32'(i); wr_be = 4'hF;
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rd_en = (k < 4); rd_addr = 8'(k);
      tick();
      checks++;
      if (rd_valid_l !== (k >= 1 && k <= 4)) begin
        errors++; $display("FAIL latency2_valid k=%0d: got %b expected %b", k, rd_valid_l, (k >= 1 && k <= 4));
      end
      exp_d = 32'hA000_0000 + 32'(k - 1);
      if (k >= 1 && k <= 4) begin
        checks++;
        if (rd_data_l !== exp_d) begin
          errors++; $display("FAIL latency2_data k=%0d: got %h expected %h", k, rd_data_l, exp_d);
        end
      end
      checks++;
      if (rd_valid_a !== (k < 4)) begin
        errors++; $display("FAIL latency1_valid k=%0d: got %b expected %b", k, rd_valid_a, (k < 4));
      end
    end
    checks++;
    if (rd_data_l !== 32'hA000_0003 || rd_data_a !== 32'hA000_0003) begin
      errors++; $display("FAIL latency_hold: got %h/%h expected a0000003", rd_data_l, rd_data_a);
    end
  endtask

  task automatic test_out_of_range();
    wr_en = 1'b1; wr_addr = 8'hF0; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'hF0;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid_s !== 1'b1 || rd_data_s !== 32'h0) begin
      errors++; $display("FAIL oor_read: got v=%b d=%h expected v=1 d=0", rd_valid_s, rd_data_s);
    end
    checks++;
    if (rd_data_a !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL oor_inrange_ref: got %h expected cafef00d", rd_data_a);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    rd_en = 1'b0; rst_n = 1'b0;
    tick();
    checks++;
    if (rd_valid_l !== 1'b0 || rd_data_l !== 32'h0) begin
      errors++; $display("FAIL midop_drop: got v=%b d=%h expected v=0 d=0", rd_valid_l, rd_data_l);
    end
    checks++;
    if ({ready_a, ready_l} !== 2'b00) begin
      errors++; $display("FAIL midop_ready: got %b expected 00", {ready_a, ready_l});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (rd_valid_l !== 1'b0) begin
      errors++; $display("FAIL midop_no_late_valid: got %b expected 0", rd_valid_l);
    end
    repeat (255) tick();
    checks++;
    if ({ready_a, ready_l} !== 2'b11) begin
      errors++; $display("FAIL midop_reinit_ready: got %b expected 11", {ready_a, ready_l});
    end
    rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h0) begin
      errors++; $display("FAIL midop_rezero: got v=%b d=%h expected v=1 d=0", rd_valid_a, rd_data_a);
    end
    tick();
    checks++;
    if (rd_valid_l !== 1'b1 || rd_data_l !== 32'h0) begin
      errors++; $display("FAIL midop_rezero_l2: got v=%b d=%h expected v=1 d=0", rd_valid_l, rd_data_l);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_byte_enable();
    test_collision();
    test_latency();
    test_out_of_range();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
